// File: rtl/slice_serial_subtractor_pkg.sv
// Shared definitions for the slice-serial subtractor and its carry-select adder sibling.
package slice_serial_subtractor_pkg;

   localparam int unsigned WIDTH_DEF = 25;
   localparam int unsigned SLICE_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Signed overflow rule shared with the adder; subtraction sees the inverted subtrahend sign.
   function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                       input logic sign_r, input logic is_sub);
      logic sign_b_eff;
      sign_b_eff = is_sub ? ~sign_b : sign_b;
      return (sign_a == sign_b_eff) && (sign_r != sign_a);
   endfunction

endpackage

// File: rtl/slice_serial_subtractor_if.sv
// Operand/result handshake bundle for the slice-serial subtractor.
interface slice_serial_subtractor_if
   import slice_serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             overflow;
   logic             borrow;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, overflow, borrow
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, overflow, borrow
   );
endinterface

// File: rtl/slice_serial_subtractor_slice_add5.sv
// Combinational ripple full-adder chain for one slice.
module slice_add5 #(
   parameter int unsigned W = 5
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   logic [W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < int'(W); i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[W];
endmodule

// File: rtl/slice_serial_subtractor.sv
// Multi-cycle signed subtractor: diff = a - b, one slice per clock, LSB slice first.
module slice_serial_subtractor
   import slice_serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SLICE = SLICE_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   slice_serial_subtractor_if.slave bus
);
   localparam int unsigned NSLICES = WIDTH / SLICE;
   localparam int unsigned CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLICES - 1);

   if ((WIDTH % SLICE) != 0 || NSLICES < 2) begin : g_bad_param
      $error("slice_serial_subtractor: WIDTH must be a multiple of SLICE with at least two slices");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               overflow_q, overflow_d;
   logic               borrow_q, borrow_d;

   logic [SLICE-1:0]   nb_slice;
   logic [SLICE-1:0]   sum;
   logic               cout;

   assign nb_slice = ~b_q[SLICE-1:0];

   // Single slice adder reused every CALC cycle; operands are pre-shifted to bit 0.
   slice_add5 #(.W(SLICE)) u_slice_add (
      .a    (a_q[SLICE-1:0]),
      .b    (nb_slice),
      .cin  (carry_q),
      .s    (sum),
      .cout (cout)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      carry_d    = carry_q;
      a_d        = a_q;
      b_d        = b_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      diff_d     = diff_q;
      overflow_d = overflow_q;
      borrow_d   = borrow_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               a_d      = bus.a;
               b_d      = bus.b;
               sign_a_d = bus.a[WIDTH-1];
               sign_b_d = bus.b[WIDTH-1];
               cnt_d    = '0;
               carry_d  = 1'b1;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            // Result slices enter at the MSB end and settle in place after the last slice.
            diff_d  = {sum, diff_q[WIDTH-1:SLICE]};
            a_d     = a_q >> SLICE;
            b_d     = b_q >> SLICE;
            carry_d = cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
               overflow_d = signed_ovf(sign_a_q, sign_b_q, sum[SLICE-1], 1'b1);
               borrow_d   = ~cout;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         diff_q     <= '0;
         overflow_q <= 1'b0;
         borrow_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         carry_q    <= carry_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         diff_q     <= diff_d;
         overflow_q <= overflow_d;
         borrow_q   <= borrow_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.diff      = diff_q;
   assign bus.overflow  = overflow_q;
   assign bus.borrow    = borrow_q;
endmodule

// File: tb/tb_slice_serial_subtractor.sv
// Scoreboard bench for slice_serial_subtractor against an arithmetic reference model.
module tb_slice_serial_subtractor;
   localparam int unsigned W = 25;

   typedef struct {
      logic [W-1:0] diff;
      logic         ov;
      logic         bw;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   slice_serial_subtractor_if #(.WIDTH(W)) bus ();

   slice_serial_subtractor #(.WIDTH(W), .SLICE(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: signed integer subtraction, range test for overflow, unsigned compare for borrow.
   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t   r;
      longint sa, sbv, d;
      sa     = longint'($signed(av));
      sbv    = longint'($signed(bv));
      d      = sa - sbv;
      r.diff = W'(d);
      r.ov   = (d > 64'sd16777215) || (d < -64'sd16777216);
      r.bw   = (av < bv);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic monitor();
      int   cyc = 0;
      bit   prev_ov = 1'b0;
      int   acc_q[$];
      int   acc;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            acc_q.delete();
            prev_ov = 1'b0;
            continue;
         end
         if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
         if (bus.out_valid && !prev_ov) begin
            if (acc_q.size() == 0) begin
               chk("stray_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               acc = acc_q.pop_front();
               chk("latency_edges", 32'(cyc - acc - 1), 32'd5);
            end
         end
         prev_ov = bus.out_valid;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 32'(bus.out_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("diff", 32'(bus.diff), 32'(e.diff));
               chk("overflow", 32'(bus.overflow), 32'(e.ov));
               chk("borrow", 32'(bus.borrow), 32'(e.bw));
            end
         end
      end
   endtask

   // Called at posedge+1; returns one cycle after the accept edge.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit rand_ready);
      int guard = 0;
      while (!bus.in_ready) begin
         if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         guard++;
         if (guard > 200) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
         end
      end
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      sb.push_back(model(av, bv));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
   endtask

   task automatic drain();
      int guard = 0;
      bus.out_ready = 1'b1;
      while (sb.size() != 0 && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   task automatic pick(output logic [W-1:0] v);
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = {1'b1, {(W-1){1'b0}}};
         2: v = {1'b0, {(W-1){1'b1}}};
         3: v = '1;
         default: v = W'($urandom);
      endcase
   endtask

   initial begin
      exp_t         e;
      logic [W-1:0] ra, rb;
      int           guard;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_diff", 32'(bus.diff), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_borrow", 32'(bus.borrow), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases: plain, negative result, overflow in both directions.
      issue(W'(100), W'(58), 1'b0);           drain();
      issue(W'(5), W'(7), 1'b0);              drain();
      issue(25'h1000000, 25'h0000001, 1'b0);  drain();
      issue(25'h0FFFFFF, 25'h1FFFFFF, 1'b0);  drain();

      // Backpressure: result must hold while the consumer stalls and new requests are ignored.
      bus.out_ready = 1'b0;
      issue(W'(1234), W'(98765), 1'b0);
      guard = 0;
      while (!bus.out_valid && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("bp_reach_done", 32'(bus.out_valid), 32'd1);
      e = model(W'(1234), W'(98765));
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = W'($urandom);
         bus.b        = W'($urandom);
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_diff", 32'(bus.diff), 32'(e.diff));
         chk("bp_flags", {30'd0, bus.overflow, bus.borrow}, {30'd0, e.ov, e.bw});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      chk("bp_release_popped", 32'(sb.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_stays_idle", 32'(bus.in_ready), 32'd1);

      // Reset after slice 2 discards the operation.
      issue(W'(123456), W'(654321), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_diff", 32'(bus.diff), 32'd0);
      chk("midrst_flags", {30'd0, bus.overflow, bus.borrow}, 32'd0);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("midrst_no_stray", 32'(bus.out_valid), 32'd0);
      issue(W'(-3), W'(-3), 1'b0);            drain();

      // Random operands, biased toward extremes, with random consumer stalls.
      for (int n = 0; n < 40; n++) begin
         pick(ra);
         pick(rb);
         issue(ra, rb, 1'b1);
      end
      drain();
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
